// File: rtl/exm_ctrl_pkg.sv
// Shared encodings for the execute-memory stack sequencer: FSM states,
// the operation being sequenced, and where {C,N,Z} sit in the flag vector.
package exm_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUSH_HI = 3'd1,
    S_PUSH_LO = 3'd2,
    S_POP_LO  = 3'd3,
    S_POP_HI  = 3'd4,
    S_LOAD    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_CALL = 2'd0,
    OP_INT  = 2'd1,
    OP_RET  = 2'd2,
    OP_RTI  = 2'd3
  } op_t;

  // Bit positions inside the 3-bit {C,N,Z} flag vector.
  localparam int FLAG_W = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/exm_stack_sequencer_pc_half_assembler.sv
// Captures the two popped PC halves (low half first) and presents the
// reassembled RET target, plus the RTI form where the top three bits of
// the high half carry the saved {C,N,Z} flags instead of PC bits.
module pc_half_assembler
  import exm_ctrl_pkg::*;
#(
  parameter int D_W = 16
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 cap_lo,
  input  logic                 cap_hi,
  input  logic [D_W-1:0]       mem_data,
  output logic [2*D_W-1:0]     pc_ret,
  output logic [2*D_W-1:0]     pc_rti,
  output logic [FLAG_W-1:0]    flags_rti
);

  logic [D_W-1:0] lo_reg;
  logic [D_W-1:0] hi_reg;

  // Register each half on the cycle its pop is on the memory read port.
  always_ff @(posedge clk) begin
    if (srst) begin
      lo_reg <= '0;
      hi_reg <= '0;
    end else begin
      if (cap_lo) lo_reg <= mem_data;
      if (cap_hi) hi_reg <= mem_data;
    end
  end

  assign pc_ret = {hi_reg, lo_reg};
  assign pc_rti = {{FLAG_W{1'b0}}, hi_reg[D_W-FLAG_W-1:0], lo_reg};

  // Flags ride in the top bits of the high half, in {C,N,Z} order.
  assign flags_rti[FLAG_C] = hi_reg[D_W-FLAG_W+FLAG_C];
  assign flags_rti[FLAG_N] = hi_reg[D_W-FLAG_W+FLAG_N];
  assign flags_rti[FLAG_Z] = hi_reg[D_W-FLAG_W+FLAG_Z];

endmodule

// File: rtl/exm_stack_sequencer.sv
// Sequences the stack for CALL / RET / RTI / interrupt entry. A 32-bit PC
// moves through the 16-bit stack as two half-word accesses; the front end
// is stalled for the whole sequence and a single PC-load pulse ends it.
module exm_stack_sequencer
  import exm_ctrl_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter int              D_W        = 16,
  parameter logic [PC_W-1:0] INT_VECTOR = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_call,
  input  logic            i_ret,
  input  logic            i_rti,
  input  logic            i_int,
  input  logic [PC_W-1:0] i_pc,
  input  logic [D_W-1:0]  i_target,
  input  logic [2:0]      i_flags,
  input  logic [D_W-1:0]  i_mem_data,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_stack_operation,
  output logic            o_stack_function,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_push_pc,
  output logic            o_pop_pc,
  output logic            o_hazard_state,
  output logic            o_branch_flags,
  output logic            o_pc_load,
  output logic [PC_W-1:0] o_pc_new,
  output logic            o_flags_load,
  output logic [2:0]      o_flags_new
);

  state_t          state_reg, state_next;
  op_t             op_reg, start_op;
  logic            start;
  logic            int_pending_reg;
  logic [D_W-1:0]  target_reg;
  logic [PC_W-1:0] pc_reg;
  logic [2:0]      flags_reg;
  logic [PC_W-1:0] pc_ret, pc_rti;
  logic [2:0]      flags_rti;

  // Snapshot of the return PC / flags at sequence start. The stage's push
  // datapath muxes the live inputs (held stable by o_stall), so nothing here
  // reads the snapshot; it is kept for debug visibility only.
  logic unused_saved;
  assign unused_saved = ^{pc_reg, flags_reg};

  pc_half_assembler #(.D_W(D_W)) u_assembler (
    .clk       (i_clk),
    .srst      (i_reset),
    .cap_lo    (state_reg == S_POP_LO),
    .cap_hi    (state_reg == S_POP_HI),
    .mem_data  (i_mem_data),
    .pc_ret    (pc_ret),
    .pc_rti    (pc_rti),
    .flags_rti (flags_rti)
  );

  // Arbitrate a new sequence in IDLE: instructions beat the pending interrupt.
  always_comb begin
    start    = 1'b0;
    start_op = OP_CALL;
    if (state_reg == S_IDLE && !i_reset) begin
      if (i_call) begin
        start = 1'b1; start_op = OP_CALL;
      end else if (i_ret) begin
        start = 1'b1; start_op = OP_RET;
      end else if (i_rti) begin
        start = 1'b1; start_op = OP_RTI;
      end else if (int_pending_reg) begin
        start = 1'b1; start_op = OP_INT;
      end
    end
  end

  // Next-state and per-state stack/memory/PC controls.
  always_comb begin
    state_next        = state_reg;
    o_stack_operation = 1'b0;
    o_stack_function  = 1'b0;
    o_mem_read        = 1'b0;
    o_mem_write       = 1'b0;
    o_push_pc         = 1'b0;
    o_pop_pc          = 1'b0;
    o_hazard_state    = 1'b0;
    o_branch_flags    = 1'b0;
    o_pc_load         = 1'b0;
    o_pc_new          = '0;
    o_flags_load      = 1'b0;
    o_flags_new       = '0;
    case (state_reg)
      S_IDLE: begin
        if (start)
          state_next = (start_op == OP_CALL || start_op == OP_INT) ? S_PUSH_HI : S_POP_LO;
      end
      S_PUSH_HI, S_PUSH_LO: begin
        o_stack_operation = 1'b1;
        o_stack_function  = 1'b1;
        o_mem_write       = 1'b1;
        o_push_pc         = 1'b1;
        o_hazard_state    = (state_reg == S_PUSH_LO);
        o_branch_flags    = (state_reg == S_PUSH_HI) && (op_reg == OP_INT);
        state_next        = (state_reg == S_PUSH_HI) ? S_PUSH_LO : S_LOAD;
      end
      S_POP_LO, S_POP_HI: begin
        o_stack_operation = 1'b1;
        o_mem_read        = 1'b1;
        o_pop_pc          = 1'b1;
        state_next        = (state_reg == S_POP_LO) ? S_POP_HI : S_LOAD;
      end
      S_LOAD: begin
        o_pc_load  = 1'b1;
        state_next = S_IDLE;
        case (op_reg)
          OP_CALL: o_pc_new = {{(PC_W-D_W){1'b0}}, target_reg};
          OP_INT:  o_pc_new = INT_VECTOR;
          OP_RET:  o_pc_new = pc_ret;
          OP_RTI: begin
            o_pc_new     = pc_rti;
            o_flags_load = 1'b1;
            o_flags_new  = flags_rti;
          end
          default: o_pc_new = '0;
        endcase
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign o_busy  = (state_reg != S_IDLE);
  assign o_stall = o_busy | start;

  // State, operation latch and sticky interrupt request.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg       <= S_IDLE;
      op_reg          <= OP_CALL;
      target_reg      <= '0;
      pc_reg          <= '0;
      flags_reg       <= '0;
      int_pending_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        op_reg <= start_op;
        pc_reg <= i_pc;
        if (start_op == OP_CALL) target_reg <= i_target;
        if (start_op == OP_INT)  flags_reg  <= i_flags;
      end
      int_pending_reg <= (int_pending_reg & ~(start && start_op == OP_INT)) | i_int;
    end
  end

endmodule

// File: tb/tb_exm_stack_sequencer.sv
// Self-checking bench for exm_stack_sequencer: directed scenarios followed by
// randomized requests, checked cycle by cycle against a transaction-level model.
module tb_exm_stack_sequencer;

  localparam logic [31:0] VEC = 32'h0000_0F00;
  localparam int K_NONE = 0, K_CALL = 1, K_INT = 2, K_RET = 3, K_RTI = 4;

  logic        i_clk = 1'b0;
  logic        i_reset, i_call, i_ret, i_rti, i_int;
  logic [31:0] i_pc;
  logic [15:0] i_target, i_mem_data;
  logic [2:0]  i_flags;
  logic        o_stall, o_busy, o_stack_operation, o_stack_function;
  logic        o_mem_read, o_mem_write, o_push_pc, o_pop_pc;
  logic        o_hazard_state, o_branch_flags, o_pc_load, o_flags_load;
  logic [31:0] o_pc_new;
  logic [2:0]  o_flags_new;

  int checks = 0;
  int errors = 0;
  bit model_pending = 1'b0;

  exm_stack_sequencer #(.PC_W(32), .D_W(16), .INT_VECTOR(VEC)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_call(i_call), .i_ret(i_ret),
    .i_rti(i_rti), .i_int(i_int), .i_pc(i_pc), .i_target(i_target),
    .i_flags(i_flags), .i_mem_data(i_mem_data),
    .o_stall(o_stall), .o_busy(o_busy), .o_stack_operation(o_stack_operation),
    .o_stack_function(o_stack_function), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_push_pc(o_push_pc), .o_pop_pc(o_pop_pc),
    .o_hazard_state(o_hazard_state), .o_branch_flags(o_branch_flags),
    .o_pc_load(o_pc_load), .o_pc_new(o_pc_new), .o_flags_load(o_flags_load),
    .o_flags_new(o_flags_new)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected control word for cycle k of a sequence (k=0 is the start cycle).
  // Order: stall busy stack_op stack_fn mem_rd mem_wr push_pc pop_pc hazard branch pc_load flags_load
  function automatic logic [11:0] exp_ctrl(input int kind, input int k);
    bit push = (kind == K_CALL) || (kind == K_INT);
    bit st = 0, bz = 0, so = 0, sf = 0, mr = 0, mw = 0, pp = 0, po = 0, hz = 0, bf = 0, pl = 0, fl = 0;
    if (kind != K_NONE) begin
      st = 1;
      bz = (k > 0);
      if (k == 1 || k == 2) begin
        so = 1;
        if (push) begin
          sf = 1; mw = 1; pp = 1;
          hz = (k == 2);
          bf = (k == 1) && (kind == K_INT);
        end else begin
          mr = 1; po = 1;
        end
      end
      if (k == 3) begin
        pl = 1;
        fl = (kind == K_RTI);
      end
    end
    return {st, bz, so, sf, mr, mw, pp, po, hz, bf, pl, fl};
  endfunction

  task automatic cycle_check(input int kind, input int k, input logic [31:0] epc, input logic [2:0] efl);
    logic [11:0] obs;
    obs = {o_stall, o_busy, o_stack_operation, o_stack_function, o_mem_read, o_mem_write,
           o_push_pc, o_pop_pc, o_hazard_state, o_branch_flags, o_pc_load, o_flags_load};
    chk($sformatf("ctrl kind%0d k%0d", kind, k), 32'(obs), 32'(exp_ctrl(kind, k)));
    chk($sformatf("pc_new kind%0d k%0d", kind, k), o_pc_new, epc);
    chk($sformatf("flags_new kind%0d k%0d", kind, k), 32'(o_flags_new), 32'(efl));
  endtask

  // One IDLE-cycle opportunity plus, if something starts, its three busy cycles.
  // noise: 0 quiet, 1 random requests while busy, 2 hold i_ret high while busy.
  task automatic run_txn(input bit c, input bit r, input bit ti, input bit it,
                         input logic [31:0] pc, input logic [15:0] tgt,
                         input logic [15:0] m_lo, input logic [15:0] m_hi,
                         input int noise, input bit reset_k2);
    int kind;
    logic [31:0] epc;
    logic [2:0] efl;
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_call = c; i_ret = r; i_rti = ti; i_int = it;
    i_pc = pc; i_target = tgt; i_flags = 3'($urandom); i_mem_data = 16'($urandom);
    kind = c ? K_CALL : r ? K_RET : ti ? K_RTI : model_pending ? K_INT : K_NONE;
    #1;
    cycle_check(kind, 0, 32'h0, 3'b0);
    if (kind == K_INT) model_pending = 1'b0;
    if (it) model_pending = 1'b1;
    $display("txn kind=%0d pc=%h tgt=%h lo=%h hi=%h noise=%0d rst=%0d", kind, pc, tgt, m_lo, m_hi, noise, reset_k2);
    if (kind == K_NONE) return;
    epc = 32'h0; efl = 3'b0;
    case (kind)
      K_CALL: epc = {16'h0000, tgt};
      K_INT:  epc = VEC;
      K_RET:  epc = {m_hi, m_lo};
      K_RTI:  begin epc = {3'b000, m_hi[12:0], m_lo}; efl = m_hi[15:13]; end
      default: epc = 32'h0;
    endcase
    for (int k = 1; k <= 3; k++) begin
      @(posedge i_clk); #1;
      i_call = (noise == 1) && ($urandom_range(0, 1) == 1);
      i_ret  = (noise == 2) || ((noise == 1) && ($urandom_range(0, 1) == 1));
      i_rti  = (noise == 1) && ($urandom_range(0, 1) == 1);
      i_int  = (noise == 1) && ($urandom_range(0, 3) == 0);
      i_pc = $urandom; i_target = 16'($urandom); i_flags = 3'($urandom);
      i_mem_data = (k == 1) ? m_lo : (k == 2) ? m_hi : 16'($urandom);
      i_reset = reset_k2 && (k == 2);
      #1;
      cycle_check(kind, k, (k == 3) ? epc : 32'h0, (k == 3) ? efl : 3'b0);
      if (i_int) model_pending = 1'b1;
      if (i_reset) begin
        model_pending = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    i_reset = 1'b1; i_call = 0; i_ret = 0; i_rti = 0; i_int = 0;
    i_pc = '0; i_target = '0; i_flags = '0; i_mem_data = '0;
    repeat (2) @(posedge i_clk);
    #1;
    cycle_check(K_NONE, 0, 32'h0, 3'b0);

    // CALL example
    run_txn(1, 0, 0, 0, 32'h0001_0024, 16'h0100, 16'h1111, 16'h2222, 0, 0);
    // RET pops low then high
    run_txn(0, 1, 0, 0, 32'h0, 16'h0, 16'h0024, 16'h0001, 0, 0);
    // RTI restores flags from the top of the high half
    run_txn(0, 0, 1, 0, 32'h0, 16'h0, 16'h0010, 16'hA005, 0, 0);
    // Interrupt coincident with CALL: CALL first, then INT, then nothing pending
    run_txn(1, 0, 0, 1, 32'h0000_1234, 16'h0456, 16'h0, 16'h0, 0, 0);
    run_txn(0, 0, 0, 0, 32'h0000_1238, 16'h0, 16'h0, 16'h0, 0, 0);
    run_txn(0, 0, 0, 0, 32'h0, 16'h0, 16'h0, 16'h0, 0, 0);
    // Reset during POP_HI aborts; idle afterwards; next RET completes
    run_txn(0, 1, 0, 0, 32'h0, 16'h0, 16'hBEEF, 16'hCAFE, 0, 1);
    run_txn(0, 0, 0, 0, 32'h0, 16'h0, 16'h0, 16'h0, 0, 0);
    run_txn(0, 1, 0, 0, 32'h0, 16'h0, 16'h5678, 16'h9ABC, 0, 0);
    // RET held high while CALL is busy: ignored, single load, idle after
    run_txn(1, 0, 0, 0, 32'h0, 16'h7777, 16'h0, 16'h0, 2, 0);
    i_ret = 1'b0;
    run_txn(0, 0, 0, 0, 32'h0, 16'h0, 16'h0, 16'h0, 0, 0);

    // Randomized mix, including coincident requests and interrupts while busy
    for (int n = 0; n < 200; n++) begin
      run_txn($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
              $urandom, 16'($urandom), 16'($urandom), 16'($urandom),
              1, $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exm_stack_sequencer.md
Name: exm_stack_sequencer

Overview:
- Multi-cycle controller that sequences the execute-memory stage's stack and data memory for CALL, RET, RTI and hardware interrupt entry.
- A 32-bit PC, plus the 3 flags for interrupts, is moved through the 16-bit stack as two half-word accesses.
- Drives the stage's stack/memory/PC-select controls and stalls the front end while busy.
- Reassembles popped PC halves and issues a single PC-load (and flag-restore) pulse at the end of each sequence.

Parameters:
INT_VECTOR, 32'h0000_0000, PC loaded on interrupt entry
PC_W, 32, program counter width
D_W, 16, memory/stack data width

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_call  in  1  CALL in execute this cycle
i_ret  in  1  RET in execute this cycle
i_rti  in  1  RTI in execute this cycle
i_int  in  1  interrupt request pulse (level or pulse, latched)
i_pc  in  PC_W  return PC to save
i_target  in  D_W  CALL target (forwarded data1)
i_flags  in  3  current {C,N,Z}
i_mem_data  in  D_W  memory read data (combinational read, same cycle)
o_stall  out  1  hold fetch/decode/execute inputs
o_busy  out  1  state != IDLE
o_stack_operation  out  1  stack enable
o_stack_function  out  1  1 push, 0 pop
o_mem_read  out  1
o_mem_write  out  1
o_push_pc  out  1  memory write data = PC half
o_pop_pc  out  1  read is a PC half
o_hazard_state  out  1  0 selects PC high half, 1 selects low half
o_branch_flags  out  1  embed/extract flags in PC[31:29]
o_pc_load  out  1  one-cycle pulse: load o_pc_new
o_pc_new  out  PC_W
o_flags_load  out  1  one-cycle pulse: restore o_flags_new
o_flags_new  out  3  {C,N,Z}

Behaviour:
- Reset: state IDLE, int_pending=0, lo/hi/target regs=0, all outputs 0. Reset mid-sequence aborts; no pulse is issued.
- States: IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI, LOAD.
- op register records CALL/INT/RET/RTI.
- int_pending set on i_int, cleared when an INT sequence starts.
- IDLE priority when several requests coincide: i_call > i_ret > i_rti > int_pending.
- Instruction requests beat interrupts; the interrupt stays pending and is serviced on the next IDLE cycle.
- Start (IDLE, cycle T): latch op, i_pc, i_target (CALL), i_flags (INT). Next state: PUSH_HI for CALL/INT, POP_LO for RET/RTI.
- o_stall = o_busy | start_this_cycle (combinational); o_busy registered.
- PUSH_HI: stack_operation=1, stack_function=1, mem_write=1, push_pc=1, hazard_state=0, branch_flags=(op==INT). Next: PUSH_LO.
- PUSH_LO: same as PUSH_HI except hazard_state=1, branch_flags=0. Next: LOAD.
- POP_LO: stack_operation=1, stack_function=0, mem_read=1, pop_pc=1. lo <= i_mem_data at clock edge. Next: POP_HI.
- POP_HI: same controls as POP_LO; hi <= i_mem_data. Next: LOAD.
- LOAD: o_pc_load=1, then IDLE.
  - CALL: o_pc_new = {16'b0, target}.
  - INT: o_pc_new = INT_VECTOR.
  - RET: o_pc_new = {hi, lo}.
  - RTI: o_pc_new = {3'b0, hi[12:0], lo}; o_flags_load=1; o_flags_new = hi[15:13].
- Latency: every sequence takes 3 busy cycles. o_pc_load is high in cycle T+3; IDLE again in T+4.
- Back-to-back: a new request may start in cycle T+4 (IDLE).
- Requests arriving while busy are ignored; upstream must hold them under o_stall. Exception: i_int is latched at any time.
- Stack-pointer wrap is the stack unit's responsibility; the sequencer places no bound on it.

Decomposition:
- Shared package exm_ctrl_pkg: state encoding (3-bit localparams S_IDLE..S_LOAD), op encoding (OP_CALL, OP_INT, OP_RET, OP_RTI), flag bit indices.
- Single module. An optional sub-module, pc_half_assembler (lo/hi capture plus RTI flag split), is a natural split.

Test Plan:
- Reset, then CALL at T with i_pc=32'h0001_0024, i_target=16'h0100:
  - T: o_stall=1.
  - T+1: push, hazard_state=0.
  - T+2: push, hazard_state=1.
  - T+3: o_pc_load=1, o_pc_new=32'h0000_0100.
- RET with i_mem_data 16'h0024 at T+1 and 16'h0001 at T+2 -> T+1/T+2 pop with mem_read=1; T+3 o_pc_new=32'h0001_0024; o_flags_load=0.
- RTI with pops 16'h0010 then 16'hA005 -> o_pc_new=32'h0005_0010, o_flags_load=1, o_flags_new=3'b101.
- i_int and i_call in the same IDLE cycle:
  - CALL runs first.
  - INT starts at T+4 with branch_flags=1 in PUSH_HI.
  - T+7: o_pc_new=INT_VECTOR.
  - int_pending=0 afterwards.
- i_reset asserted in POP_HI -> next cycle all outputs 0, IDLE, no o_pc_load; a following RET completes normally.
- i_ret pulsed while busy (PUSH_LO) -> ignored; exactly one o_pc_load for the original CALL.
